// File: rtl/lv_ctrl_fsm_gen.sv
// Low-voltage die control FSM: power-up, efuse load, configuration, test and PWM operation,
// with a generic maskable error vector split into fatal and recoverable channels.
module lv_ctrl_fsm_gen #(
  parameter int unsigned ERR_NUM    = 15,
  parameter int unsigned PWR_ON_DLY = 16,
  parameter int unsigned EFUSE_TO   = 1024,
  parameter int unsigned RECOV_CYC  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pwr_on,
  input  logic               i_test_mode,
  input  logic               i_cfg_req,
  input  logic               i_efuse_done,
  input  logic               i_fsenb_n,
  input  logic [ERR_NUM-1:0] i_err,
  input  logic [ERR_NUM-1:0] i_err_mask,
  input  logic [ERR_NUM-1:0] i_err_fatal,
  input  logic               i_flt_clr,
  output logic [2:0]         o_state,
  output logic               o_efuse_load,
  output logic               o_pwm_en,
  output logic               o_cfg_mode_status,
  output logic               o_test_mode_status,
  output logic               o_fault,
  output logic               o_efuse_to,
  output logic [ERR_NUM-1:0] o_err_latch
);

  localparam int unsigned PON_W = $clog2(PWR_ON_DLY + 1);
  localparam int unsigned TO_W  = $clog2(EFUSE_TO + 1);
  localparam int unsigned RC_W  = $clog2(RECOV_CYC + 1);

  localparam logic [PON_W-1:0] PON_LAST = PON_W'(PWR_ON_DLY - 1);
  localparam logic [PON_W-1:0] PON_MAX  = PON_W'(PWR_ON_DLY);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(EFUSE_TO - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(EFUSE_TO);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RECOV_CYC - 1);
  localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(RECOV_CYC);

  typedef enum logic [2:0] {
    ST_PWR_DN   = 3'd0,
    ST_EFUSE    = 3'd1,
    ST_CFG      = 3'd2,
    ST_NORMAL   = 3'd3,
    ST_FAILSAFE = 3'd4,
    ST_FAULT    = 3'd5,
    ST_TEST     = 3'd6,
    ST_UNUSED   = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [PON_W-1:0]   pon_cnt_q, pon_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [RC_W-1:0]    rc_cnt_q, rc_cnt_d;
  logic [ERR_NUM-1:0] err_latch_q, err_latch_d;
  logic               efuse_to_q, efuse_to_d;
  logic               efuse_load_q, efuse_load_d;
  logic               pwm_en_q, pwm_en_d;
  logic               cfg_status_q, cfg_status_d;
  logic               test_status_q, test_status_d;
  logic               fault_q, fault_d;

  logic [ERR_NUM-1:0] eff_err;
  logic               fat, rec, eval_err, clean;

  // Error classification
  always_comb begin
    eff_err  = i_err & ~i_err_mask;
    fat      = |(eff_err & i_err_fatal);
    rec      = |(eff_err & ~i_err_fatal);
    clean    = !rec && i_fsenb_n;
    eval_err = (state_q == ST_CFG) || (state_q == ST_NORMAL) || (state_q == ST_FAILSAFE);
  end

  // Next state, counters and sticky flags; counters only advance while staying in their state
  always_comb begin
    state_d     = state_q;
    pon_cnt_d   = '0;
    to_cnt_d    = '0;
    rc_cnt_d    = '0;
    err_latch_d = err_latch_q;
    efuse_to_d  = efuse_to_q;

    if (i_flt_clr) begin
      err_latch_d = err_latch_q & eff_err;
      efuse_to_d  = 1'b0;
    end
    if (eval_err) begin
      err_latch_d = err_latch_d | eff_err;
    end

    if (!i_pwr_on) begin
      state_d     = ST_PWR_DN;
      err_latch_d = '0;
      efuse_to_d  = 1'b0;
    end else begin
      case (state_q)
        ST_PWR_DN: begin
          if (pon_cnt_q == PON_LAST) state_d = ST_EFUSE;
          else pon_cnt_d = (pon_cnt_q == PON_MAX) ? pon_cnt_q : pon_cnt_q + PON_W'(1);
        end
        ST_EFUSE: begin
          if (i_efuse_done) begin
            state_d = i_test_mode ? ST_TEST : ST_CFG;
          end else if (to_cnt_q == TO_LAST) begin
            state_d    = ST_FAULT;
            efuse_to_d = 1'b1;
          end else begin
            to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TO_W'(1);
          end
        end
        ST_CFG: begin
          if (fat)                    state_d = ST_FAULT;
          else if (i_test_mode)       state_d = ST_TEST;
          else if (rec || !i_fsenb_n) state_d = ST_FAILSAFE;
          else if (!i_cfg_req)        state_d = ST_NORMAL;
        end
        ST_NORMAL: begin
          if (fat)                    state_d = ST_FAULT;
          else if (rec || !i_fsenb_n) state_d = ST_FAILSAFE;
          else if (i_test_mode)       state_d = ST_TEST;
          else if (i_cfg_req)         state_d = ST_CFG;
        end
        ST_FAILSAFE: begin
          if (fat)                   state_d = ST_FAULT;
          else if (i_cfg_req)        state_d = ST_CFG;
          else if (clean) begin
            if (rc_cnt_q == RC_LAST) state_d = ST_NORMAL;
            else rc_cnt_d = (rc_cnt_q == RC_MAX) ? rc_cnt_q : rc_cnt_q + RC_W'(1);
          end
        end
        ST_FAULT: begin
          if (i_flt_clr && !fat) state_d = ST_CFG;
        end
        ST_TEST: begin
          if (!i_test_mode) state_d = ST_CFG;
        end
        default: state_d = ST_PWR_DN;
      endcase
    end
  end

  // Output decode from the next state so outputs line up with o_state
  always_comb begin
    efuse_load_d  = (state_d == ST_EFUSE) && (state_q != ST_EFUSE);
    pwm_en_d      = (state_d == ST_NORMAL) && i_fsenb_n;
    cfg_status_d  = (state_d == ST_CFG);
    test_status_d = (state_d == ST_TEST);
    fault_d       = (state_d == ST_FAULT);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_PWR_DN;
      pon_cnt_q     <= '0;
      to_cnt_q      <= '0;
      rc_cnt_q      <= '0;
      err_latch_q   <= '0;
      efuse_to_q    <= 1'b0;
      efuse_load_q  <= 1'b0;
      pwm_en_q      <= 1'b0;
      cfg_status_q  <= 1'b0;
      test_status_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pon_cnt_q     <= pon_cnt_d;
      to_cnt_q      <= to_cnt_d;
      rc_cnt_q      <= rc_cnt_d;
      err_latch_q   <= err_latch_d;
      efuse_to_q    <= efuse_to_d;
      efuse_load_q  <= efuse_load_d;
      pwm_en_q      <= pwm_en_d;
      cfg_status_q  <= cfg_status_d;
      test_status_q <= test_status_d;
      fault_q       <= fault_d;
    end
  end

  assign o_state            = state_q;
  assign o_efuse_load       = efuse_load_q;
  assign o_pwm_en           = pwm_en_q;
  assign o_cfg_mode_status  = cfg_status_q;
  assign o_test_mode_status = test_status_q;
  assign o_fault            = fault_q;
  assign o_efuse_to         = efuse_to_q;
  assign o_err_latch        = err_latch_q;

endmodule

// File: doc/lv_ctrl_fsm_gen.md
# lv_ctrl_fsm_gen

Parametrised low-voltage-die control state machine, the successor to the fixed-input LV control FSM. It sequences power-up, efuse load, configuration, test and normal PWM operation. A generic ERR_NUM-wide error vector with per-channel mask and fatal/recoverable classification replaces the hard-wired error list. It sits between the register bank and the PWM/one-wire datapath; its mode-status outputs gate register write/read permission.

## Interface
- ERR_NUM, 15, number of error channels (≥1)
- PWR_ON_DLY, 16, consecutive i_pwr_on-high cycles required before leaving PWR_DN (≥1)
- EFUSE_TO, 1024, max cycles in EFUSE waiting for i_efuse_done (≥1)
- RECOV_CYC, 8, consecutive clean cycles required to leave FAILSAFE (≥1)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; one clock; reset is synchronous and active-high
- i_pwr_on  in  1  supply-good level
- i_test_mode  in  1  test-mode request, level
- i_cfg_req  in  1  configuration-mode request, level
- i_efuse_done  in  1  efuse load complete, level
- i_fsenb_n  in  1  failsafe enable, 0 = failsafe requested
- i_err  in  ERR_NUM  raw error flags, level, bit n = channel n
- i_err_mask  in  ERR_NUM  1 = channel ignored
- i_err_fatal  in  ERR_NUM  1 = fatal (FAULT), 0 = recoverable (FAILSAFE)
- i_flt_clr  in  1  single-cycle fault/latch clear pulse
- o_state  out  3  current state encoding
- o_efuse_load  out  1  one-cycle pulse on entry to EFUSE
- o_pwm_en  out  1  PWM drive enable
- o_cfg_mode_status  out  1  state == CFG
- o_test_mode_status  out  1  state == TEST
- o_fault  out  1  state == FAULT
- o_efuse_to  out  1  sticky efuse timeout flag
- o_err_latch  out  ERR_NUM  sticky effective-error record

## Operation
- Encoding: PWR_DN=0, EFUSE=1, CFG=2, NORMAL=3, FAILSAFE=4, FAULT=5, TEST=6; 7 unused and returns to PWR_DN.
- eff_err = i_err & ~i_err_mask; fat = |(eff_err & i_err_fatal); rec = |(eff_err & ~i_err_fatal). Errors are evaluated only in CFG, NORMAL and FAILSAFE.
- Global priority: i_rst > (i_pwr_on==0 → PWR_DN, from any state other than PWR_DN; clears counters, o_err_latch and o_efuse_to) > state-local rules.
- PWR_DN: pon_cnt increments while i_pwr_on=1 and clears to 0 when it is 0. At pon_cnt==PWR_ON_DLY-1 with i_pwr_on=1 → EFUSE.
- EFUSE: to_cnt counts from 0. i_efuse_done=1 → TEST if i_test_mode, else CFG. to_cnt==EFUSE_TO-1 without done → FAULT and o_efuse_to←1. If done and timeout coincide, done wins.
- CFG: fat → FAULT; else i_test_mode → TEST; else rec or !i_fsenb_n → FAILSAFE; else !i_cfg_req → NORMAL.
- NORMAL: fat → FAULT; else rec or !i_fsenb_n → FAILSAFE; else i_test_mode → TEST; else i_cfg_req → CFG.
- FAILSAFE: fat → FAULT; else i_cfg_req → CFG; else rc_cnt counts consecutive cycles with !rec && i_fsenb_n, resets to 0 otherwise; at rc_cnt==RECOV_CYC-1 while clean → NORMAL.
- FAULT: i_flt_clr && !fat → CFG; a pulse while fat is present is ignored for the transition.
- TEST: i_test_mode=0 → CFG. Errors are ignored.
- o_err_latch: each cycle in an evaluating state, latch |= eff_err. i_flt_clr (any state) clears the bits that are not currently in eff_err; set wins over clear in the same cycle.
- o_efuse_to cleared by i_flt_clr, by i_pwr_on=0 and by reset.
- Counter widths are $clog2(param+1); counters saturate and never wrap. Counters clear on every state change.

## Timing
- Reset values: o_state=0, o_efuse_load=0, o_pwm_en=0, all status outputs 0, o_efuse_to=0, o_err_latch=0, all counters 0.
- All outputs are registered. They are decoded from the next state so they align with o_state in the same cycle.
- Moore behaviour: a condition sampled at edge k changes o_state at edge k. o_pwm_en = (state==NORMAL) && i_fsenb_n registered, so an error at edge k drops o_pwm_en after edge k (1-cycle latency).
- o_efuse_load is high exactly one cycle, the first cycle o_state==EFUSE.
- Minimum reset-to-EFUSE with i_pwr_on held high is PWR_ON_DLY cycles.

## Test plan
- Power-up: PWR_ON_DLY=4, i_pwr_on high from cycle 0, i_efuse_done after 3 cycles, i_cfg_req=0 → EFUSE at cycle 4 with 1-cycle o_efuse_load, then CFG, then NORMAL, o_pwm_en=1.
- Glitchy i_pwr_on: low at pon_cnt=2 → counter restarts; EFUSE entered only after 4 clean cycles.
- Efuse timeout: EFUSE_TO=8, no done → FAULT at cycle 8, o_efuse_to=1, o_fault=1; i_flt_clr → CFG, o_efuse_to=0.
- Recoverable error: NORMAL, i_err[3] pulse (not fatal, not masked) → FAILSAFE next edge, o_pwm_en=0, o_err_latch=0x0008; NORMAL after RECOV_CYC clean cycles. Masked channel → no transition and no latch.
- Fatal error with clear: i_err[0] fatal held, i_flt_clr pulse → stays FAULT; error drops, then i_flt_clr → CFG and latch bit 0 cleared.
- i_pwr_on drops in FAILSAFE with i_flt_clr in the same cycle → PWR_DN, latch=0, counters=0.
